uart_program_loader: RTL and testbench
======================================

Name: uart_program_loader

Overview:
- Sits directly downstream of the UART receiver in the boot path of the core's top level.
- Consumes the received-byte stream and reads a 32-bit word-count header.
- Packs the following bytes into 32-bit instruction words and writes them to instruction memory at consecutive addresses.
- On completion, returns an 8-bit checksum through the UART transmitter and raises done so the core can leave reset.

Parameters:
- ADDR_WIDTH, 14: instruction-memory word-address width. Depth is 2^ADDR_WIDTH words.

Ports:
- clk  in  1  system clock (100 MHz).
- rstn  in  1  reset.
- rx_data  in  8  received byte from the UART receiver.
- rx_valid  in  1  one-cycle pulse; rx_data is valid in that cycle.
- rx_ferr  in  1  one-cycle pulse, coincident with rx_valid, marking a framing error (bad stop bit).
- tx_busy  in  1  UART transmitter busy.
- tx_start  out  1  one-cycle request to transmit tx_data.
- tx_data  out  8  byte to transmit.
- imem_we  out  1  instruction-memory write enable, one cycle per word.
- imem_addr  out  ADDR_WIDTH  word address.
- imem_wdata  out  32  instruction word.
- loading  out  1  high from the first header byte until DONE.
- done  out  1  load complete.
- err  out  1  sticky error flag.

Behaviour:
- Clocking and reset:
  - Single clock clk. Reset rstn is asynchronous and active-low.
  - While rstn=0, all outputs are 0 and state=HDR. Internal byte_cnt=0, word_cnt=0, addr=0, csum=0.
  - Deasserting rstn mid-load discards all progress; the next byte is treated as header byte 0.
- Byte packing (both header and data):
  - Big-endian: the first byte of each group of 4 goes to [31:24], the last to [7:0].
  - byte_cnt is 2 bits and counts bytes accepted within the current word.
- Accepting bytes:
  - A byte is accepted only in a cycle with rx_valid=1 and rx_ferr=0, and only in state HDR or DATA.
  - rx_valid=1 with rx_ferr=1: byte discarded, err<=1, byte_cnt unchanged, state unchanged.
- States:
  - HDR:
    - Accepts 4 bytes forming N, the word count.
    - On the 4th byte, the next cycle is DATA if N!=0, else CKSUM.
    - loading rises the cycle after the first accepted header byte.
  - DATA:
    - On each 4th byte of a word, the next cycle drives imem_we=1, imem_addr=addr, imem_wdata=packed word. Latency is exactly 1 cycle from that rx_valid.
    - After the write: addr<=addr+1 (wraps modulo 2^ADDR_WIDTH), word_cnt<=word_cnt+1.
    - When word_cnt reaches N, go to CKSUM in the cycle of the final write.
    - csum <= csum + byte (mod 256) for every accepted data byte. Header bytes are excluded.
  - Oversize loads:
    - N > 2^ADDR_WIDTH: err<=1 at header completion.
    - The loader still consumes all N words. Writes with word_cnt >= 2^ADDR_WIDTH are suppressed (imem_we stays 0), so memory is never overwritten by wrap.
  - CKSUM:
    - Waits while tx_busy=1.
    - In the first cycle with tx_busy=0, pulses tx_start=1 for exactly one cycle with tx_data=csum, then goes to DONE.
    - tx_data holds csum until reset.
  - DONE:
    - done=1 and loading=0.
    - All rx_valid pulses are ignored, including ones carrying rx_ferr; err does not change.
    - Leaves DONE only on rstn=0.
- Output holds: imem_addr and imem_wdata hold their last values when imem_we=0. imem_we is never high for 2 consecutive cycles.
- Back-to-back bytes: rx_valid may arrive in consecutive cycles (stub source). Every pulse must be handled without loss.
- Simultaneous events: rx_valid in the same cycle that CKSUM is entered is ignored.

Test Plan:
- Normal load:
  - Stimulus: header 00 00 00 02, then data 12 34 56 78 9A BC DE F0, bytes 10 cycles apart.
  - Required: imem writes addr0=0x12345678 and addr1=0x9ABCDEF0, each 1 cycle after the 4th byte. tx_start once with tx_data=0x38. done=1, err=0.
- Zero-length load:
  - Stimulus: header 00 00 00 00.
  - Required: no imem_we. tx_start with tx_data=0x00. done=1.
- tx backpressure:
  - Stimulus: normal load with tx_busy held 1 for 50 cycles after the last write.
  - Required: tx_start asserts in the first cycle tx_busy=0, exactly once.
- Framing error:
  - Stimulus: in the normal load, the 3rd data byte arrives with rx_ferr=1, and a correct 56 is resent afterwards.
  - Required: err=1. Words are identical to the normal load. Checksum = 0x38.
- Reset mid-load:
  - Stimulus: rstn pulsed low after 6 data bytes, then the full normal load is sent.
  - Required: outputs 0 during reset. Final memory and checksum match the normal load. addr restarts at 0.
- Oversize:
  - Stimulus: ADDR_WIDTH=2, header N=5, 5 words of data.
  - Required: writes to addr 0..3 only. err=1. Checksum covers all 20 data bytes. done=1.

Source files
------------

// File: rtl/uart_program_loader_if.sv
// Boot-loader bus bundle: UART rx/tx handshakes, instruction-memory write port
// and loader status. master = loader side, slave = surrounding boot fabric.
interface uart_program_loader_if #(
   parameter int ADDR_WIDTH = 14
);
   logic [7:0]            rx_data;
   logic                  rx_valid;
   logic                  rx_ferr;
   logic                  tx_busy;
   logic                  tx_start;
   logic [7:0]            tx_data;
   logic                  imem_we;
   logic [ADDR_WIDTH-1:0] imem_addr;
   logic [31:0]           imem_wdata;
   logic                  loading;
   logic                  done;
   logic                  err;

   modport master (
      input  rx_data, rx_valid, rx_ferr, tx_busy,
      output tx_start, tx_data, imem_we, imem_addr, imem_wdata, loading, done, err
   );

   modport slave (
      output rx_data, rx_valid, rx_ferr, tx_busy,
      input  tx_start, tx_data, imem_we, imem_addr, imem_wdata, loading, done, err
   );
endinterface

// File: rtl/uart_program_loader.sv
// UART program loader: reads a 32-bit big-endian word count, packs the following
// bytes into instruction words, writes them to imem, then returns an 8-bit sum.
//
// state  | meaning
// -------+-----------------------------------------------------------
// HDR    | collecting the 4 header bytes (word count N)
// DATA   | collecting data bytes, one imem write per 4 bytes
// CKSUM  | waiting for the transmitter to go idle, then send csum
// DONE   | load finished; all rx traffic ignored until reset
module uart_program_loader #(
   parameter int ADDR_WIDTH = 14
) (
   input logic                    clk,
   input logic                    rstn,
   uart_program_loader_if.master  bus
);
   localparam logic [1:0]  S_HDR   = 2'd0;
   localparam logic [1:0]  S_DATA  = 2'd1;
   localparam logic [1:0]  S_CKSUM = 2'd2;
   localparam logic [1:0]  S_DONE  = 2'd3;
   localparam logic [32:0] DEPTH   = 33'd1 << ADDR_WIDTH;

   logic [1:0]            state_q, state_d;
   logic [1:0]            byte_cnt_q, byte_cnt_d;
   logic [23:0]           word_q, word_d;
   logic [31:0]           n_q, n_d;
   logic [31:0]           word_cnt_q, word_cnt_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [7:0]            csum_q, csum_d;
   logic                  loading_q, loading_d;
   logic                  err_q, err_d;
   logic                  imem_we_q, imem_we_d;
   logic [ADDR_WIDTH-1:0] imem_addr_q, imem_addr_d;
   logic [31:0]           imem_wdata_q, imem_wdata_d;

   logic                  rx_window;
   logic                  accept;
   logic                  ferr_hit;
   logic                  last_byte;
   logic [31:0]           full_word;

   assign rx_window = (state_q == S_HDR) || (state_q == S_DATA);
   assign accept    = bus.rx_valid && !bus.rx_ferr && rx_window;
   assign ferr_hit  = bus.rx_valid && bus.rx_ferr && rx_window;
   assign last_byte = (byte_cnt_q == 2'd3);
   assign full_word = {word_q, bus.rx_data};

   // Next-state logic: byte packing, header capture, imem writes, checksum, tx hand-off
   always_comb begin
      state_d      = state_q;
      byte_cnt_d   = byte_cnt_q;
      word_d       = word_q;
      n_d          = n_q;
      word_cnt_d   = word_cnt_q;
      addr_d       = addr_q;
      csum_d       = csum_q;
      loading_d    = loading_q;
      err_d        = err_q;
      imem_we_d    = 1'b0;
      imem_addr_d  = imem_addr_q;
      imem_wdata_d = imem_wdata_q;

      if (ferr_hit) begin
         err_d = 1'b1;
      end

      if (accept) begin
         byte_cnt_d = byte_cnt_q + 2'd1;
         word_d     = {word_q[15:0], bus.rx_data};
         if (state_q == S_HDR) begin
            loading_d = 1'b1;
            if (last_byte) begin
               n_d = full_word;
               if ({1'b0, full_word} > DEPTH) begin
                  err_d = 1'b1;
               end
               state_d = (full_word != 32'd0) ? S_DATA : S_CKSUM;
            end
         end else begin
            csum_d = csum_q + bus.rx_data;
            if (last_byte) begin
               // Words beyond the memory depth are consumed but never written,
               // so an oversize image cannot wrap onto already-loaded code.
               if ({1'b0, word_cnt_q} < DEPTH) begin
                  imem_we_d    = 1'b1;
                  imem_addr_d  = addr_q;
                  imem_wdata_d = full_word;
               end
               addr_d     = addr_q + 1'b1;
               word_cnt_d = word_cnt_q + 32'd1;
               if ((word_cnt_q + 32'd1) == n_q) begin
                  state_d = S_CKSUM;
               end
            end
         end
      end

      if ((state_q == S_CKSUM) && !bus.tx_busy) begin
         state_d   = S_DONE;
         loading_d = 1'b0;
      end
   end

   // State and datapath registers, cleared asynchronously
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q      <= S_HDR;
         byte_cnt_q   <= 2'd0;
         word_q       <= 24'd0;
         n_q          <= 32'd0;
         word_cnt_q   <= 32'd0;
         addr_q       <= '0;
         csum_q       <= 8'd0;
         loading_q    <= 1'b0;
         err_q        <= 1'b0;
         imem_we_q    <= 1'b0;
         imem_addr_q  <= '0;
         imem_wdata_q <= 32'd0;
      end else begin
         state_q      <= state_d;
         byte_cnt_q   <= byte_cnt_d;
         word_q       <= word_d;
         n_q          <= n_d;
         word_cnt_q   <= word_cnt_d;
         addr_q       <= addr_d;
         csum_q       <= csum_d;
         loading_q    <= loading_d;
         err_q        <= err_d;
         imem_we_q    <= imem_we_d;
         imem_addr_q  <= imem_addr_d;
         imem_wdata_q <= imem_wdata_d;
      end
   end

   // tx_start is combinational so it fires in the very first idle cycle of the transmitter
   always_comb begin
      bus.tx_start = (state_q == S_CKSUM) && !bus.tx_busy;
      bus.tx_data  = ((state_q == S_CKSUM) || (state_q == S_DONE)) ? csum_q : 8'h00;
   end

   assign bus.imem_we    = imem_we_q;
   assign bus.imem_addr  = imem_addr_q;
   assign bus.imem_wdata = imem_wdata_q;
   assign bus.loading    = loading_q;
   assign bus.done       = (state_q == S_DONE);
   assign bus.err        = err_q;
endmodule

// File: tb/tb_uart_program_loader.sv
// Directed bench for uart_program_loader: a full-size instance and a 4-word
// instance for the oversize case, sharing the same rx/tx stimulus wires.
module tb_uart_program_loader;
   logic       clk = 1'b0;
   logic       rstn_a, rstn_o;
   logic [7:0] rx_data;
   logic       rx_valid, rx_ferr, tx_busy;

   always #5 clk = ~clk;

   uart_program_loader_if #(.ADDR_WIDTH(14)) ifa ();
   uart_program_loader_if #(.ADDR_WIDTH(2))  ifo ();

   assign ifa.rx_data  = rx_data;
   assign ifa.rx_valid = rx_valid;
   assign ifa.rx_ferr  = rx_ferr;
   assign ifa.tx_busy  = tx_busy;
   assign ifo.rx_data  = rx_data;
   assign ifo.rx_valid = rx_valid;
   assign ifo.rx_ferr  = rx_ferr;
   assign ifo.tx_busy  = tx_busy;

   uart_program_loader #(.ADDR_WIDTH(14)) dut_a (.clk(clk), .rstn(rstn_a), .bus(ifa));
   uart_program_loader #(.ADDR_WIDTH(2))  dut_o (.clk(clk), .rstn(rstn_o), .bus(ifo));

   int tests = 0;
   int fails = 0;
   int cyc   = 0;
   int last_cyc;
   int bc[0:1];

   always @(posedge clk) cyc <= cyc + 1;

   // write / transmit monitors sampled on the falling edge
   logic [13:0] wa_addr [0:15];
   logic [31:0] wa_data [0:15];
   int          wa_cyc  [0:15];
   int          na, b2b_a, txa_cnt, txa_cyc, txa_busy;
   logic [7:0]  txa_val;
   logic        prev_we_a, prev_we_o;
   logic [1:0]  wo_addr [0:15];
   logic [31:0] wo_data [0:15];
   int          no, b2b_o, txo_cnt;
   logic [7:0]  txo_val;

   always @(negedge clk) begin
      if (ifa.imem_we) begin
         if (na < 16) begin
            wa_addr[na] = ifa.imem_addr;
            wa_data[na] = ifa.imem_wdata;
            wa_cyc[na]  = cyc;
         end
         na++;
         if (prev_we_a) b2b_a++;
      end
      prev_we_a = ifa.imem_we;
      if (ifa.tx_start) begin
         txa_cnt++;
         txa_val = ifa.tx_data;
         txa_cyc = cyc;
         if (tx_busy) txa_busy++;
      end
      if (ifo.imem_we) begin
         if (no < 16) begin
            wo_addr[no] = ifo.imem_addr;
            wo_data[no] = ifo.imem_wdata;
         end
         no++;
         if (prev_we_o) b2b_o++;
      end
      prev_we_o = ifo.imem_we;
      if (ifo.tx_start) begin
         txo_cnt++;
         txo_val = ifo.tx_data;
      end
   end

   task automatic clear_mon();
      na = 0; b2b_a = 0; txa_cnt = 0; txa_cyc = -1; txa_busy = 0; txa_val = 8'h00;
      no = 0; b2b_o = 0; txo_cnt = 0; txo_val = 8'h00;
   endtask

   // called at a falling edge; returns at a falling edge
   task automatic send_byte(input logic [7:0] b, input logic ferr, input int gap);
      rx_data  = b;
      rx_valid = 1'b1;
      rx_ferr  = ferr;
      last_cyc = cyc;
      @(negedge clk);
      rx_valid = 1'b0;
      rx_ferr  = 1'b0;
      repeat (gap) @(negedge clk);
   endtask

   task automatic send_word(input logic [31:0] w, input int gap);
      for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8], 1'b0, gap);
   endtask

   task automatic reset_all();
      rstn_a = 1'b0;
      rstn_o = 1'b0;
      repeat (3) @(negedge clk);
      rstn_a = 1'b1;
      clear_mon();
   endtask

   task automatic load_normal(input int gap);
      send_word(32'h0000_0002, gap);
      send_word(32'h1234_5678, gap);
      bc[0] = last_cyc;
      send_word(32'h9ABC_DEF0, gap);
      bc[1] = last_cyc;
   endtask

   task automatic check_normal_words(input string tag, input bit check_lat);
      logic [31:0] exp_w [0:1];
      exp_w[0] = 32'h1234_5678;
      exp_w[1] = 32'h9ABC_DEF0;
      tests++;
      if (na !== 2) begin
         fails++;
         $display("FAIL %s_wr_count: got %0d want 2", tag, na);
      end
      for (int i = 0; i < 2; i++) begin
         tests++;
         if (wa_addr[i] !== 14'(i) || wa_data[i] !== exp_w[i]) begin
            fails++;
            $display("FAIL %s_word%0d: got addr %0d data %h want addr %0d data %h",
                     tag, i, wa_addr[i], wa_data[i], i, exp_w[i]);
         end
         if (check_lat) begin
            tests++;
            if (wa_cyc[i] !== bc[i] + 1) begin
               fails++;
               $display("FAIL %s_lat%0d: got cycle %0d want %0d", tag, i, wa_cyc[i], bc[i] + 1);
            end
         end
      end
      tests++;
      if (txa_cnt !== 1 || txa_val !== 8'h38) begin
         fails++;
         $display("FAIL %s_tx: got %0d starts data %h want 1 start data 38", tag, txa_cnt, txa_val);
      end
      tests++;
      if (ifa.done !== 1'b1 || ifa.loading !== 1'b0 || ifa.tx_data !== 8'h38) begin
         fails++;
         $display("FAIL %s_final: got done %b loading %b tx_data %h want 1 0 38",
                  tag, ifa.done, ifa.loading, ifa.tx_data);
      end
   endtask

   task automatic test_reset();
      rstn_a = 1'b0;
      rstn_o = 1'b0;
      repeat (2) @(negedge clk);
      tests++;
      if ({ifa.tx_start, ifa.tx_data, ifa.imem_we, ifa.imem_addr, ifa.imem_wdata,
           ifa.loading, ifa.done, ifa.err} !== '0) begin
         fails++;
         $display("FAIL reset_outputs: got we %b addr %h wdata %h tx %b/%h ld %b dn %b er %b want all 0",
                  ifa.imem_we, ifa.imem_addr, ifa.imem_wdata, ifa.tx_start, ifa.tx_data,
                  ifa.loading, ifa.done, ifa.err);
      end
   endtask

   task automatic test_normal();
      reset_all();
      send_byte(8'h00, 1'b0, 9);
      tests++;
      if (ifa.loading !== 1'b1 || ifa.done !== 1'b0) begin
         fails++;
         $display("FAIL normal_loading: got loading %b done %b want 1 0", ifa.loading, ifa.done);
      end
      send_byte(8'h00, 1'b0, 9);
      send_byte(8'h00, 1'b0, 9);
      send_byte(8'h02, 1'b0, 9);
      send_word(32'h1234_5678, 9);
      bc[0] = last_cyc;
      send_word(32'h9ABC_DEF0, 9);
      bc[1] = last_cyc;
      repeat (5) @(negedge clk);
      check_normal_words("normal", 1'b1);
      tests++;
      if (ifa.err !== 1'b0 || b2b_a !== 0) begin
         fails++;
         $display("FAIL normal_err: got err %b b2b %0d want 0 0", ifa.err, b2b_a);
      end
   endtask

   task automatic test_zero_length();
      reset_all();
      send_word(32'h0000_0000, 3);
      repeat (5) @(negedge clk);
      tests++;
      if (na !== 0 || txa_cnt !== 1 || txa_val !== 8'h00 || ifa.done !== 1'b1) begin
         fails++;
         $display("FAIL zero_len: got writes %0d starts %0d data %h done %b want 0 1 00 1",
                  na, txa_cnt, txa_val, ifa.done);
      end
   endtask

   task automatic test_backpressure();
      int drop_cyc;
      reset_all();
      tx_busy = 1'b1;
      load_normal(9);
      repeat (50) @(negedge clk);
      tests++;
      if (txa_cnt !== 0 || ifa.done !== 1'b0) begin
         fails++;
         $display("FAIL bp_hold: got starts %0d done %b want 0 0", txa_cnt, ifa.done);
      end
      @(posedge clk);
      #1 tx_busy = 1'b0;
      drop_cyc = cyc;
      @(negedge clk);
      repeat (5) @(negedge clk);
      tests++;
      if (txa_cnt !== 1 || txa_cyc !== drop_cyc || txa_busy !== 0) begin
         fails++;
         $display("FAIL bp_release: got starts %0d at %0d busy_hits %0d want 1 at %0d 0",
                  txa_cnt, txa_cyc, txa_busy, drop_cyc);
      end
      check_normal_words("bp", 1'b0);
   endtask

   task automatic test_framing_error();
      reset_all();
      send_word(32'h0000_0002, 9);
      send_byte(8'h12, 1'b0, 9);
      send_byte(8'h34, 1'b0, 9);
      send_byte(8'hFF, 1'b1, 9);
      tests++;
      if (ifa.err !== 1'b1 || na !== 0) begin
         fails++;
         $display("FAIL ferr_flag: got err %b writes %0d want 1 0", ifa.err, na);
      end
      send_byte(8'h56, 1'b0, 9);
      send_byte(8'h78, 1'b0, 9);
      bc[0] = last_cyc;
      send_word(32'h9ABC_DEF0, 9);
      bc[1] = last_cyc;
      repeat (5) @(negedge clk);
      check_normal_words("ferr", 1'b1);
      tests++;
      if (ifa.err !== 1'b1) begin
         fails++;
         $display("FAIL ferr_sticky: got err %b want 1", ifa.err);
      end
   endtask

   task automatic test_reset_mid_load();
      reset_all();
      send_word(32'h0000_0002, 9);
      send_word(32'h1234_5678, 9);
      send_byte(8'h9A, 1'b0, 9);
      send_byte(8'hBC, 1'b0, 9);
      rstn_a = 1'b0;
      @(negedge clk);
      tests++;
      if ({ifa.tx_start, ifa.tx_data, ifa.imem_we, ifa.imem_addr, ifa.imem_wdata,
           ifa.loading, ifa.done, ifa.err} !== '0) begin
         fails++;
         $display("FAIL midrst_outputs: got addr %h wdata %h loading %b want all 0",
                  ifa.imem_addr, ifa.imem_wdata, ifa.loading);
      end
      @(negedge clk);
      rstn_a = 1'b1;
      clear_mon();
      load_normal(9);
      repeat (5) @(negedge clk);
      check_normal_words("midrst", 1'b1);
   endtask

   task automatic test_back_to_back();
      reset_all();
      load_normal(0);
      repeat (5) @(negedge clk);
      check_normal_words("b2b", 1'b1);
      tests++;
      if (b2b_a !== 0 || ifa.err !== 1'b0) begin
         fails++;
         $display("FAIL b2b_we: got consecutive writes %0d err %b want 0 0", b2b_a, ifa.err);
      end
   endtask

   task automatic test_done_ignore();
      send_byte(8'hAA, 1'b1, 0);
      send_byte(8'h55, 1'b0, 0);
      send_word(32'h0102_0304, 0);
      repeat (3) @(negedge clk);
      tests++;
      if (ifa.err !== 1'b0 || na !== 2 || ifa.done !== 1'b1 || txa_cnt !== 1 || ifa.tx_data !== 8'h38) begin
         fails++;
         $display("FAIL done_ignore: got err %b writes %0d done %b starts %0d tx_data %h want 0 2 1 1 38",
                  ifa.err, na, ifa.done, txa_cnt, ifa.tx_data);
      end
   endtask

   task automatic test_oversize();
      reset_all();
      rstn_a = 1'b0;
      rstn_o = 1'b1;
      @(negedge clk);
      send_word(32'h0000_0005, 2);
      tests++;
      if (ifo.err !== 1'b1) begin
         fails++;
         $display("FAIL over_hdr_err: got err %b want 1", ifo.err);
      end
      for (int i = 1; i <= 20; i++) send_byte(8'(i), 1'b0, 2);
      repeat (5) @(negedge clk);
      tests++;
      if (no !== 4) begin
         fails++;
         $display("FAIL over_wr_count: got %0d want 4", no);
      end
      for (int i = 0; i < 4; i++) begin
         logic [31:0] ew;
         ew = {8'(4*i + 1), 8'(4*i + 2), 8'(4*i + 3), 8'(4*i + 4)};
         tests++;
         if (wo_addr[i] !== 2'(i) || wo_data[i] !== ew) begin
            fails++;
            $display("FAIL over_word%0d: got addr %0d data %h want addr %0d data %h",
                     i, wo_addr[i], wo_data[i], i, ew);
         end
      end
      tests++;
      if (txo_cnt !== 1 || txo_val !== 8'hD2 || ifo.done !== 1'b1 || ifo.err !== 1'b1 || b2b_o !== 0) begin
         fails++;
         $display("FAIL over_final: got starts %0d data %h done %b err %b b2b %0d want 1 D2 1 1 0",
                  txo_cnt, txo_val, ifo.done, ifo.err, b2b_o);
      end
      rstn_o = 1'b0;
   endtask

   initial begin
      rstn_a   = 1'b0;
      rstn_o   = 1'b0;
      rx_data  = 8'h00;
      rx_valid = 1'b0;
      rx_ferr  = 1'b0;
      tx_busy  = 1'b0;
      clear_mon();
      prev_we_a = 1'b0;
      prev_we_o = 1'b0;
      @(negedge clk);
      test_reset();
      test_normal();
      test_zero_length();
      test_backpressure();
      test_framing_error();
      test_reset_mid_load();
      test_back_to_back();
      test_done_ignore();
      test_oversize();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
